// File: rtl/psr_pkg.sv
// Shared types and helpers for the psr1 chain loader.
//   psr_state_e   : loader FSM states
//   MODE_SERIAL   : shift the word in MSB-first, one bit per shift pulse
//   MODE_PARALLEL : load the whole word with one shift pulse
//   bit_period()  : clk cycles per shift pulse (setup + pulse + hold)
package psr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold
  } psr_state_e;

  localparam logic MODE_SERIAL   = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;

  function automatic int unsigned bit_period(input int unsigned sep, input int unsigned hold);
    return sep + 1 + hold;
  endfunction

endpackage

// File: rtl/psr_wait_timer.sv
// Loadable down-counter used to space the shift pulse from its surrounding data changes.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load (cycles remaining minus one)
//   zero_o     : counter has reached zero
// The counter stops at zero rather than wrapping.
module psr_wait_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/psr_loader.sv
// Upstream feeder for a chain of WIDTH psr1 cells. Accepts one word per valid/ready handshake
// and drives sin/pin/shift_clk with SEP_CYCLES of setup and HOLD_CYCLES of hold around each
// shift pulse.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : word handshake; in_data and in_mode captured on accept
//   in_mode           : 0 serial MSB-first shift-in, 1 single-pulse parallel load
//   sin, pin          : serial and parallel data to the chain
//   shift_clk         : one-cycle shift pulse
//   busy, done        : transfer in progress / one-cycle completion pulse
// All outputs are flops; their next values are derived from the next state.
module psr_loader
  import psr_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SEP_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             sin,
  output logic [WIDTH-1:0] pin,
  output logic             shift_clk,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MaxWait = (SEP_CYCLES > HOLD_CYCLES) ? SEP_CYCLES : HOLD_CYCLES;
  localparam int unsigned WaitW   = $clog2(MaxWait + 1);
  localparam int unsigned BitW    = $clog2(WIDTH + 1);

  // Timer is loaded with length-1 so the zero flag marks the last cycle of the state.
  localparam logic [WaitW-1:0] SepLoad  = WaitW'(SEP_CYCLES - 1);
  localparam logic [WaitW-1:0] HoldLoad = (HOLD_CYCLES > 0) ? WaitW'(HOLD_CYCLES - 1) : '0;
  localparam logic [BitW-1:0]  LastBit  = BitW'(WIDTH - 1);

  psr_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;

  logic             timer_load;
  logic [WaitW-1:0] timer_val;
  logic             wait_zero;
  logic             bit_end;
  logic             finish;

  logic             sin_q, sin_d;
  logic [WIDTH-1:0] pin_q, pin_d;
  logic             shift_clk_q, shift_clk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;

  psr_wait_timer #(
    .W(WaitW)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .zero_o    (wait_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      mode_q    <= MODE_SERIAL;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    timer_load = 1'b0;
    timer_val  = SepLoad;
    bit_end    = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          state_d    = StSetup;
          data_d     = in_data;
          mode_d     = in_mode;
          bit_cnt_d  = '0;
          timer_load = 1'b1;
        end
      end
      StSetup: begin
        if (wait_zero) begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (HOLD_CYCLES != 0) begin
          state_d    = StHold;
          timer_load = 1'b1;
          timer_val  = HoldLoad;
        end else begin
          bit_end = 1'b1;
        end
      end
      StHold: begin
        if (wait_zero) begin
          bit_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // End of a bit period: either start the next serial bit or finish the word.
    if (bit_end) begin
      if (mode_q == MODE_PARALLEL || bit_cnt_q == LastBit) begin
        state_d = StIdle;
        finish  = 1'b1;
      end else begin
        state_d    = StSetup;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        data_d     = data_q << 1;
        timer_load = 1'b1;
        timer_val  = SepLoad;
      end
    end
  end

  // Output logic: registered outputs follow the state being entered.
  always_comb begin
    busy_d      = (state_d != StIdle);
    in_ready_d  = (state_d == StIdle);
    shift_clk_d = (state_d == StPulse);
    done_d      = finish;
    sin_d       = (busy_d && mode_d == MODE_SERIAL) ? data_d[WIDTH-1] : 1'b0;
    pin_d       = (busy_d && mode_d == MODE_PARALLEL) ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q       <= 1'b0;
      pin_q       <= '0;
      shift_clk_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      sin_q       <= sin_d;
      pin_q       <= pin_d;
      shift_clk_q <= shift_clk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign sin       = sin_q;
  assign pin       = pin_q;
  assign shift_clk = shift_clk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_psr_loader.sv
// Bench for psr_loader: instance 0 uses HOLD_CYCLES=1 (P=4), instance 1 HOLD_CYCLES=0 (P=3).
// Stimulus pushes expected shift-pulse and done events into a per-instance queue; a monitor
// per instance pops and compares whenever shift_clk or done is seen.
module tb_psr_loader;
  import psr_pkg::*;

  typedef struct packed {
    logic       is_done;
    int         cyc;
    logic       sin;
    logic [3:0] pin;
    int         busy_n;
    int         sin_n;
  } ev_t;

  localparam int P0 = int'(bit_period(2, 1));
  localparam int P1 = int'(bit_period(2, 0));

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid[2];
  logic       in_ready[2];
  logic       in_mode[2];
  logic [3:0] in_data[2];
  logic       sin[2];
  logic [3:0] pin[2];
  logic       shift_clk[2];
  logic       busy[2];
  logic       done[2];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic d, input int c, input logic s, input logic [3:0] p,
                             input int bn, input int sn);
    ev_t e;
    e.is_done = d;
    e.cyc     = c;
    e.sin     = s;
    e.pin     = p;
    e.busy_n  = bn;
    e.sin_n   = sn;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Hold = (g == 0) ? 1 : 0;

    psr_loader #(
      .WIDTH      (4),
      .SEP_CYCLES (2),
      .HOLD_CYCLES(Hold)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_mode  (in_mode[g]),
      .sin      (sin[g]),
      .pin      (pin[g]),
      .shift_clk(shift_clk[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );

    logic prev_sclk = 1'b0;
    int   bcnt = 0;
    int   scnt = 0;

    always @(negedge clk) begin : mon
      ev_t act, e;
      if (rst) begin
        prev_sclk = 1'b0;
        bcnt      = 0;
        scnt      = 0;
      end else begin
        if (shift_clk[g] && prev_sclk) begin
          checks++;
          errors++;
          $display("FAIL dut%0d sclk_consecutive at cyc %0d: got 1 twice, want isolated", g, cyc);
        end
        prev_sclk = shift_clk[g];
        if (busy[g]) begin
          bcnt++;
          if (sin[g]) scnt++;
        end else begin
          checks++;
          if (sin[g] !== 1'b0 || pin[g] !== 4'h0) begin
            errors++;
            $display("FAIL dut%0d idle_out at cyc %0d: got sin=%0b pin=%h, want 0/0",
                     g, cyc, sin[g], pin[g]);
          end
        end
        if (shift_clk[g] || done[g]) begin
          act = mk(done[g], cyc, sin[g], pin[g], done[g] ? bcnt : 0, done[g] ? scnt : 0);
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected_event: got done=%0b cyc=%0d, want none",
                     g, act.is_done, act.cyc);
          end else begin
            e = exp_q[g].pop_front();
            if (act !== e) begin
              errors++;
              $display({"FAIL dut%0d event: got done=%0b cyc=%0d sin=%0b pin=%h busy_n=%0d ",
                        "sin_n=%0d, want done=%0b cyc=%0d sin=%0b pin=%h busy_n=%0d sin_n=%0d"},
                       g, act.is_done, act.cyc, act.sin, act.pin, act.busy_n, act.sin_n,
                       e.is_done, e.cyc, e.sin, e.pin, e.busy_n, e.sin_n);
            end
          end
          if (done[g]) begin
            bcnt = 0;
            scnt = 0;
          end
        end
      end
    end
  end

  // Offer a word and queue the events the chain should see for it.
  task automatic send(input int g, input logic [3:0] d, input logic m, input bit keep);
    int p, base, t, ones;
    p = (g == 0) ? P0 : P1;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    in_mode[g]  = m;
    t = 0;
    while (!in_ready[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[g]) begin
      checks++;
      errors++;
      $display("FAIL dut%0d accept_timeout: got in_ready=0, want 1", g);
      in_valid[g] = 1'b0;
      return;
    end
    base = cyc + 1;  // cycle c of this transfer is seen at cyc == base + c - 1
    if (m == MODE_SERIAL) begin
      ones = 0;
      for (int k = 0; k < 4; k++) begin
        exp_q[g].push_back(mk(1'b0, base + k * p + 2, d[3-k], 4'h0, 0, 0));
        ones += int'(d[3-k]);
      end
      exp_q[g].push_back(mk(1'b1, base + 4 * p, 1'b0, 4'h0, 4 * p, ones * p));
    end else begin
      exp_q[g].push_back(mk(1'b0, base + 2, 1'b0, d, 0, 0));
      exp_q[g].push_back(mk(1'b1, base + p, 1'b0, 4'h0, p, 0));
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid[g] = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy[0] || busy[1]) begin
      errors++;
      $display("FAIL drain %s: got pending=%0d/%0d busy=%0b/%0b, want 0/0 0/0", name,
               exp_q[0].size(), exp_q[1].size(), busy[0], busy[1]);
    end
  endtask

  task automatic check_zero(input int g, input string name);
    checks++;
    if ({sin[g], pin[g], shift_clk[g], busy[g], done[g], in_ready[g]} !== 9'h0) begin
      errors++;
      $display("FAIL dut%0d %s: got sin=%0b pin=%h sclk=%0b busy=%0b done=%0b rdy=%0b, want 0",
               g, name, sin[g], pin[g], shift_clk[g], busy[g], done[g], in_ready[g]);
    end
  endtask

  task automatic check_ready(input int g, input string name);
    checks++;
    if (in_ready[g] !== 1'b1 || done[g] !== 1'b0) begin
      errors++;
      $display("FAIL dut%0d %s: got in_ready=%0b done=%0b, want 1/0",
               g, name, in_ready[g], done[g]);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = 4'h0;
      in_mode[g]  = MODE_SERIAL;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    @(negedge clk);
    check_ready(0, "ready_after_reset");
    check_ready(1, "ready_after_reset");

    send(0, 4'b1011, MODE_SERIAL, 1'b0);
    drain("serial_1011");
    send(0, 4'hA, MODE_PARALLEL, 1'b0);
    drain("parallel_A");

    send(1, 4'b0001, MODE_SERIAL, 1'b0);
    drain("hold0_serial_0001");
    send(1, 4'h6, MODE_PARALLEL, 1'b0);
    drain("hold0_parallel_6");

    // Back-to-back: valid stays high, second word taken in the done cycle.
    send(0, 4'b1100, MODE_SERIAL, 1'b1);
    send(0, 4'b0011, MODE_SERIAL, 1'b0);
    drain("back_to_back");

    // Offer while busy in cycle 8: must be ignored.
    send(0, 4'b0110, MODE_SERIAL, 1'b0);
    repeat (8) @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hF;
    in_mode[0]  = MODE_PARALLEL;
    @(negedge clk);
    in_valid[0] = 1'b0;
    drain("ignore_busy");

    // Reset in cycle 6 of a serial transfer.
    send(0, 4'b1001, MODE_SERIAL, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_q[0].delete();
    @(negedge clk);
    check_zero(0, "rst_abort");
    rst = 1'b0;
    @(negedge clk);
    check_ready(0, "rst_recover");
    send(0, 4'b0101, MODE_SERIAL, 1'b0);
    drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
